// File: rtl/issue_queue.sv
// Circular FIFO between the scheduler's issue port and the execute stage.
// Head is presented first-word fall-through; a write into a full queue with no pop is dropped and sets a sticky overflow.
package issue_queue_pkg;
    typedef struct packed {
        logic [3:0]  optype;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [15:0] vj;
        logic [15:0] vk;
        logic [7:0]  rob_tag;
    } res_st_cell_t;
endpackage

module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     fifo_wr_en,
    input  res_st_cell_t             op_in,
    output res_st_cell_t             op_out,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    res_st_cell_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;

    logic wr_req;
    logic push;
    logic pop;

    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AFULL_LEVEL));
    assign op_valid    = (count_q != '0) && en;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign op_out      = (count_q != '0) ? mem[rd_ptr_q] : '0;

    assign wr_req = en && fifo_wr_en;
    assign pop    = op_valid && op_ready;
    // A full queue still accepts a write when the head leaves on the same edge.
    assign push   = wr_req && (!full || pop) && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_req && full && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= op_in;
    end

endmodule

// File: tb/tb_issue_queue.sv
// Randomised and directed stimulus for issue_queue, checked against a queue-based reference model.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int AFULL = DEPTH - 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic           flush = 1'b0;
    logic           fifo_wr_en = 1'b0;
    res_st_cell_t   op_in = '0;
    res_st_cell_t   op_out;
    logic           op_valid;
    logic           op_ready = 1'b0;
    logic           full;
    logic           almost_full;
    logic [3:0]     count;
    logic           overflow;

    issue_queue #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .flush       (flush),
        .fifo_wr_en  (fifo_wr_en),
        .op_in       (op_in),
        .op_out      (op_out),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    res_st_cell_t model_q[$];
    logic         model_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        res_st_cell_t head;
        int sz;
        sz   = model_q.size();
        head = (sz != 0) ? model_q[0] : '0;
        check_eq("count",       64'(count),       64'(sz));
        check_eq("op_valid",    64'(op_valid),    64'((sz != 0) && en));
        check_eq("op_out",      64'(op_out),      64'(head));
        check_eq("full",        64'(full),        64'(sz == DEPTH));
        check_eq("almost_full", 64'(almost_full), 64'(sz >= AFULL));
        check_eq("overflow",    64'(overflow),    64'(model_ovf));
    endtask

    // Apply one cycle of inputs at the falling edge, check, then advance the model across the rising edge.
    task automatic cyc(input logic e, input logic f, input logic w, input res_st_cell_t c, input logic r);
        logic valid, pop, push;
        en = e; flush = f; fifo_wr_en = w; op_in = c; op_ready = r;
        #1;
        check_outputs();
        valid = (model_q.size() != 0) && e;
        pop   = valid && r;
        push  = e && w && ((model_q.size() < DEPTH) || pop);
        if (f) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (pop)  void'(model_q.pop_front());
            if (push) model_q.push_back(c);
            if (e && w && !push) model_ovf = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic res_st_cell_t rand_cell();
        res_st_cell_t c;
        c.optype  = 4'($urandom);
        c.qj      = 4'($urandom);
        c.qk      = 4'($urandom);
        c.vj      = 16'($urandom);
        c.vk      = 16'($urandom);
        c.rob_tag = 8'($urandom);
        return c;
    endfunction

    function automatic res_st_cell_t tag_cell(input int t);
        res_st_cell_t c;
        c = rand_cell();
        c.rob_tag = 8'(t);
        return c;
    endfunction

    initial begin
        res_st_cell_t c;
        int wr_pct, rd_pct;

        en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_outputs();
        rst = 1'b1;
        @(negedge clk);

        // Single push with qj=qk=0, optype[0]=1, then pop.
        c = tag_cell(8'hA5);
        c.qj = '0; c.qk = '0; c.optype[0] = 1'b1;
        cyc(1, 0, 1, c, 0);
        cyc(1, 0, 0, '0, 1);
        cyc(1, 0, 0, '0, 0);

        // Fill with tags 1..8, pop three, push 9..11, hold 5 stalled cycles, drain.
        for (int t = 1; t <= 8; t++) cyc(1, 0, 1, tag_cell(t), 0);
        for (int i = 0; i < 3; i++)  cyc(1, 0, 0, '0, 1);
        for (int t = 9; t <= 11; t++) cyc(1, 0, 1, tag_cell(t), 0);
        // Overflow: drop when not popping, accept when popping.
        cyc(1, 0, 1, tag_cell(8'hEE), 0);
        cyc(1, 0, 1, tag_cell(12), 1);
        for (int i = 0; i < 5; i++)  cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 9; i++)  cyc(1, 0, 0, '0, 1);

        // Flush at count 5 together with a push, then en low ignores everything.
        for (int t = 1; t <= 5; t++) cyc(1, 0, 1, tag_cell(t), 0);
        cyc(1, 1, 1, tag_cell(99), 0);
        for (int t = 1; t <= 3; t++) cyc(1, 0, 1, tag_cell(t), 0);
        cyc(0, 0, 1, tag_cell(77), 1);
        cyc(0, 0, 1, tag_cell(78), 1);
        cyc(1, 0, 0, '0, 0);

        // Random traffic across differently biased phases.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin wr_pct = 70; rd_pct = 30; end
                1: begin wr_pct = 30; rd_pct = 70; end
                2: begin wr_pct = 50; rd_pct = 50; end
                default: begin wr_pct = 90; rd_pct = 15; end
            endcase
            for (int i = 0; i < 500; i++)
                cyc($urandom_range(99) < 90, $urandom_range(99) < 1,
                    $urandom_range(99) < wr_pct, rand_cell(),
                    $urandom_range(99) < rd_pct);
        end

        // Asynchronous reset between edges with four entries queued.
        cyc(1, 1, 0, '0, 0);
        for (int t = 1; t <= 4; t++) cyc(1, 0, 1, tag_cell(t), 0);
        en = 1'b1; fifo_wr_en = 1'b0; op_ready = 1'b0; flush = 1'b0;
        #1;
        check_eq("pre_rst_count", 64'(count), 64'(4));
        #1;
        rst = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        check_eq("async_rst_count", 64'(count), 64'(0));
        check_eq("async_rst_valid", 64'(op_valid), 64'(0));
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 0, 1, tag_cell(42), 0);
        cyc(1, 0, 0, '0, 1);
        cyc(1, 0, 0, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Receiving end of the schedule stage's issue interface (`fifo_wr_en` / `op_out`).
- Buffers ready-to-execute reservation-station cells in a circular FIFO.
- Presents the oldest cell to the execute stage over a valid/ready handshake.
- Reports occupancy and backpressure status, and records a sticky error when the scheduler writes while the queue is full.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- AFULL_LEVEL, DEPTH-2, occupancy at or above which `almost_full` asserts.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-low reset.
- en  input  1  stage enable; when low, no push or pop occurs.
- flush  input  1  synchronous pipeline flush; empties the queue.
- fifo_wr_en  input  1  push request from the schedule stage.
- op_in  input  $bits(res_st_cell_t)  cell to push (`res_st_cell_t`).
- op_out  output  $bits(res_st_cell_t)  head cell (`res_st_cell_t`).
- op_valid  output  1  head cell is valid.
- op_ready  input  1  execute stage accepts the head cell.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AFULL_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a push was dropped.

Behaviour:
- **State:** storage array `mem[DEPTH]`, write pointer `wr_ptr` and read pointer `rd_ptr` (each $clog2(DEPTH) bits, wrap modulo DEPTH), occupancy counter `count`, and sticky `overflow`.
- **Reset** (rst low, asynchronous): `wr_ptr = rd_ptr = 0`, `count = 0`, `overflow = 0`. Consequently `op_valid = 0`, `full = 0`, `almost_full = 0` (AFULL_LEVEL >= 1), and `op_out = 0`. Storage contents need not be reset. Reset asserted mid-operation discards all entries immediately. The first push is allowed on the first rising edge after rst deasserts.
- **push** = en && fifo_wr_en && (!full || pop).
- **pop** = en && op_valid && op_ready.
- **Push:** writes `op_in` to `mem[wr_ptr]` and sets `wr_ptr = wr_ptr + 1`.
- **Pop:** sets `rd_ptr = rd_ptr + 1`.
- **Count update:**
  - +1 on push-only.
  - −1 on pop-only.
  - Unchanged on push and pop in the same cycle, or on neither.
- **Full with simultaneous pop:** a write while full is accepted when a pop occurs in the same cycle. count stays DEPTH.
- **Full without pop:** if en && fifo_wr_en && full && !pop, the push is dropped and `overflow` sets to 1 on that edge and holds. The schedule stage has no stall input, so this is the error path.
- **Outputs:**
  - `op_valid = (count != 0) && en`.
  - `op_out = mem[rd_ptr]` when count != 0, else 0.
  - `op_out` is combinational from registered state (first-word fall-through).
- **Latency:** a push into an empty queue is visible on `op_valid` / `op_out` in the cycle after the push edge. Data cannot pass straight through in the same cycle.
- **Simultaneous push and pop on an empty queue:** cannot occur, because `op_valid` = 0 when empty.
- **Hold while stalled:** while `op_valid && !op_ready`, `op_out` must remain stable.
- **en low:** pointers, count and overflow hold. `op_valid` = 0. `fifo_wr_en` is ignored and does not set `overflow`.
- **flush** (synchronous, has priority over push and pop, effective regardless of en): `wr_ptr = rd_ptr = 0`, `count = 0`, `overflow = 0`. A push in the flush cycle is discarded.
- **Ordering:** strict FIFO order, with no reordering or bypass.
- **Pointer wrap:** natural overflow of the $clog2(DEPTH)-bit pointers.
- **Assertions** (for the verification engineer):
  - count <= DEPTH.
  - `!(full && count != DEPTH)`.
  - `op_out` is stable while `op_valid && !op_ready`.

Test Plan:
1. **Reset then single push.** Hold rst low for 3 cycles with en=1. Push one cell with qj=0, qk=0, optype[0]=1 → cycle after push edge: op_valid=1, op_out equals the pushed cell, count=1. Set op_ready=1 for one cycle → the next cycle has count=0 and op_valid=0.
2. **Fill and wrap (DEPTH=8).** Push 8 cells tagged 1..8 with op_ready=0 → full=1, count=8; almost_full is 1 from count=6 onward. Pop 3 (tags 1,2,3 in order), then push 3 tagged 9..11 → the drain order is 4..11 and wr_ptr wraps to 3.
3. **Overflow.** With the queue full and op_ready=0, pulse fifo_wr_en → overflow=1, count stays 8 and the dropped cell never appears. Repeat with op_ready=1 → the push is accepted, count=8, overflow unchanged.
4. **Backpressure.** Hold op_ready=0 for 5 cycles with a valid head → op_out stays bit-identical; then raise op_ready → tags drain one per cycle.
5. **Flush and en.** With count=5, assert flush together with fifo_wr_en → next cycle count=0, op_valid=0, overflow=0. With en=0, pulse fifo_wr_en and op_ready → no state change and op_valid=0.
6. **Asynchronous reset mid-stream.** Assert rst between clock edges with count=4 → count=0 and op_valid=0 immediately, without waiting for a clock edge.
